// File: rtl/mem_stage_lsu_if.sv
// Data-memory request/acknowledge bus between the M-stage LSU and data memory.
// Latency: none; wires only.
// Backpressure: request and attributes are held by the master until ack or timeout.
interface mem_stage_lsu_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    logic                  req;
    logic                  we;
    logic [ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] wdata;
    logic [3:0]            be;
    logic [DATA_WIDTH-1:0] rdata;
    logic                  ack;

    modport master (
        output req, we, addr, wdata, be,
        input  rdata, ack
    );

    modport slave (
        input  req, we, addr, wdata, be,
        output rdata, ack
    );
endinterface

// File: rtl/mem_stage_lsu.sv
// M-stage load/store unit: turns load/store controls into a req/ack memory access.
// Latency: 3 cycles minimum (IDLE, BUSY with same-cycle ack, DONE), +1 per ack wait.
// Backpressure: mem_stall freezes F/D/E/M until DONE; a silent memory ends in a bus error.
module mem_stage_lsu #(
    parameter int DATA_WIDTH     = 32,
    parameter int ADDR_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  M_mem_read,
    input  logic                  M_mem_write,
    input  logic [2:0]            M_funct3,
    input  logic [ADDR_WIDTH-1:0] M_addr,
    input  logic [DATA_WIDTH-1:0] M_write_data,
    output logic                  mem_stall,
    output logic [DATA_WIDTH-1:0] M_mem_data,
    output logic                  M_misaligned,
    output logic                  M_bus_err,
    mem_stage_lsu_if.master       dmem
);

    // Counter only has to reach TIMEOUT_CYCLES-1; the terminal BUSY cycle is the compare hit.
    localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t                state;
    state_t                next_state;
    logic [CW-1:0]         cnt;
    logic [2:0]            ld_funct3;
    logic [1:0]            ld_lane;
    logic                  access;
    logic                  is_half;
    logic                  is_word;
    logic                  misalign;
    logic                  start;
    logic                  tmo_hit;
    logic [3:0]            st_be;
    logic [DATA_WIDTH-1:0] st_wdata;

    // Sub-word load extraction; unknown width codes fall back to a full word.
    function automatic logic [DATA_WIDTH-1:0] extend(input logic [2:0]            f3,
                                                     input logic [1:0]            lane,
                                                     input logic [DATA_WIDTH-1:0] rd);
        logic [7:0]  b;
        logic [15:0] h;
        b = rd[{lane, 3'b000} +: 8];
        h = lane[1] ? rd[31:16] : rd[15:0];
        case (f3)
            3'b000:  extend = {{(DATA_WIDTH-8){b[7]}}, b};
            3'b100:  extend = {{(DATA_WIDTH-8){1'b0}}, b};
            3'b001:  extend = {{(DATA_WIDTH-16){h[15]}}, h};
            3'b101:  extend = {{(DATA_WIDTH-16){1'b0}}, h};
            default: extend = rd;
        endcase
    endfunction

    // Alignment check and access qualification; a store takes precedence over a load.
    always_comb begin
        access   = M_mem_read | M_mem_write;
        is_half  = (M_funct3 == 3'b001) || (!M_mem_write && M_funct3 == 3'b101);
        is_word  = (M_funct3 == 3'b010);
        misalign = (is_half && M_addr[0]) || (is_word && (M_addr[1:0] != 2'b00));
        start    = !rst && access && !misalign;
        tmo_hit  = (TIMEOUT_CYCLES != 0) && (cnt == CW'(TIMEOUT_CYCLES - 1));
    end

    // Store lane steering; loads fetch the whole word and extract locally.
    always_comb begin
        st_be    = 4'hF;
        st_wdata = M_write_data;
        if (!M_mem_write) begin
            st_wdata = '0;
        end else begin
            case (M_funct3)
                3'b000: begin
                    st_be    = 4'b0001 << M_addr[1:0];
                    st_wdata = {4{M_write_data[7:0]}};
                end
                3'b001: begin
                    st_be    = 4'b0011 << {M_addr[1], 1'b0};
                    st_wdata = {2{M_write_data[15:0]}};
                end
                default: begin
                    st_be    = 4'hF;
                    st_wdata = M_write_data;
                end
            endcase
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= next_state;
    end

    // Next-state and stall/request decode.
    always_comb begin
        next_state   = state;
        mem_stall    = 1'b0;
        M_misaligned = 1'b0;
        dmem.req     = 1'b0;
        case (state)
            IDLE: begin
                M_misaligned = !rst && access && misalign;
                mem_stall    = start;
                if (start) next_state = BUSY;
            end
            BUSY: begin
                dmem.req  = 1'b1;
                mem_stall = 1'b1;
                if (dmem.ack || tmo_hit) next_state = DONE;
            end
            DONE:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Bus attributes latched at launch, load capture on ack, timeout bookkeeping.
    always_ff @(posedge clk) begin
        if (rst) begin
            dmem.we    <= 1'b0;
            dmem.addr  <= '0;
            dmem.wdata <= '0;
            dmem.be    <= 4'h0;
            ld_funct3  <= 3'b000;
            ld_lane    <= 2'b00;
            cnt        <= '0;
            M_mem_data <= '0;
            M_bus_err  <= 1'b0;
        end else begin
            M_bus_err <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        dmem.we    <= M_mem_write;
                        dmem.addr  <= {M_addr[ADDR_WIDTH-1:2], 2'b00};
                        dmem.wdata <= st_wdata;
                        dmem.be    <= st_be;
                        ld_funct3  <= M_funct3;
                        ld_lane    <= M_addr[1:0];
                        cnt        <= '0;
                    end
                end
                BUSY: begin
                    if (dmem.ack) begin
                        if (!dmem.we) M_mem_data <= extend(ld_funct3, ld_lane, dmem.rdata);
                    end else if (tmo_hit) begin
                        M_mem_data <= '0;
                        M_bus_err  <= 1'b1;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_stage_lsu.sv
// Directed bench for mem_stage_lsu with a reactive memory responder.
// Latency: ack is returned a programmable number of cycles after req.
// Backpressure: access loop follows mem_stall until the DONE cycle.
module tb_mem_stage_lsu;

    logic        clk;
    logic        rst;
    logic        M_mem_read;
    logic        M_mem_write;
    logic [2:0]  M_funct3;
    logic [31:0] M_addr;
    logic [31:0] M_write_data;
    logic        mem_stall;
    logic [31:0] M_mem_data;
    logic        M_misaligned;
    logic        M_bus_err;

    mem_stage_lsu_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) dmem ();

    mem_stage_lsu #(
        .DATA_WIDTH    (32),
        .ADDR_WIDTH    (32),
        .TIMEOUT_CYCLES(4)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .M_mem_read  (M_mem_read),
        .M_mem_write (M_mem_write),
        .M_funct3    (M_funct3),
        .M_addr      (M_addr),
        .M_write_data(M_write_data),
        .mem_stall   (mem_stall),
        .M_mem_data  (M_mem_data),
        .M_misaligned(M_misaligned),
        .M_bus_err   (M_bus_err),
        .dmem        (dmem)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec;
    int n_bad;

    // Results of the most recent access.
    int          stall_cnt;
    int          req_cnt;
    int          err_cnt;
    logic        saw_mis;
    logic        done_seen;
    logic [31:0] done_dat;
    logic        done_err;
    logic        cap_we;
    logic [31:0] cap_addr;
    logic [3:0]  cap_be;
    logic [31:0] cap_wdata;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
        end
    endtask

    // Launch one access and follow it to its DONE (or misaligned) cycle.
    task automatic run_access(input logic rd, input logic wr, input logic [2:0] f3,
                              input logic [31:0] a, input logic [31:0] wd,
                              input int ack_wait, input logic [31:0] rdat);
        int k;
        stall_cnt = 0; req_cnt = 0; err_cnt = 0; saw_mis = 1'b0;
        done_seen = 1'b0; done_dat = '0; done_err = 1'b0; k = 0;
        @(posedge clk); #1;
        M_mem_read = rd; M_mem_write = wr; M_funct3 = f3; M_addr = a; M_write_data = wd;
        while (!done_seen && k < 300) begin
            @(negedge clk);
            if (M_misaligned) saw_mis = 1'b1;
            if (M_bus_err) err_cnt++;
            if (mem_stall) stall_cnt++;
            if (dmem.req) begin
                if (req_cnt == 0) begin
                    cap_we = dmem.we; cap_addr = dmem.addr; cap_be = dmem.be; cap_wdata = dmem.wdata;
                end
                if (req_cnt == ack_wait) begin
                    dmem.ack = 1'b1; dmem.rdata = rdat;
                end
                req_cnt++;
            end
            if (!mem_stall && !dmem.req) begin
                done_seen = 1'b1; done_dat = M_mem_data; done_err = M_bus_err;
            end
            @(posedge clk); #1;
            dmem.ack = 1'b0;
            k++;
        end
        M_mem_read = 1'b0; M_mem_write = 1'b0;
        check("access_completes", {31'b0, done_seen}, 32'd1);
    endtask

    initial begin
        n_vec = 0; n_bad = 0;
        rst = 1'b1; M_mem_read = 1'b0; M_mem_write = 1'b0; M_funct3 = 3'b000;
        M_addr = '0; M_write_data = '0; dmem.ack = 1'b0; dmem.rdata = '0;
        cap_we = 1'b0; cap_addr = '0; cap_be = '0; cap_wdata = '0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        // Reset state
        @(negedge clk);
        check("rst_stall", {31'b0, mem_stall}, 32'd0);
        check("rst_req", {31'b0, dmem.req}, 32'd0);
        check("rst_we", {31'b0, dmem.we}, 32'd0);
        check("rst_addr", dmem.addr, 32'h0);
        check("rst_be", {28'b0, dmem.be}, 32'h0);
        check("rst_wdata", dmem.wdata, 32'h0);
        check("rst_data", M_mem_data, 32'h0);
        check("rst_mis", {31'b0, M_misaligned}, 32'd0);
        check("rst_err", {31'b0, M_bus_err}, 32'd0);

        // 1: reset during BUSY, late ack ignored
        @(posedge clk); #1;
        M_mem_read = 1'b1; M_funct3 = 3'b010; M_addr = 32'h300;
        @(negedge clk);
        check("t1_idle_stall", {31'b0, mem_stall}, 32'd1);
        @(posedge clk); #1;
        @(negedge clk);
        check("t1_busy_req", {31'b0, dmem.req}, 32'd1);
        @(posedge clk); #1;
        rst = 1'b1; M_mem_read = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0; dmem.ack = 1'b1; dmem.rdata = 32'hCAFEF00D;
        @(negedge clk);
        check("t1_req_after_rst", {31'b0, dmem.req}, 32'd0);
        check("t1_stall_after_rst", {31'b0, mem_stall}, 32'd0);
        @(posedge clk); #1 dmem.ack = 1'b0;
        @(negedge clk);
        check("t1_no_capture", M_mem_data, 32'h0);

        // 2: LW with three wait cycles
        run_access(1'b1, 1'b0, 3'b010, 32'h100, 32'h0, 3, 32'hDEADBEEF);
        check("t2_addr", cap_addr, 32'h100);
        check("t2_be", {28'b0, cap_be}, 32'hF);
        check("t2_we", {31'b0, cap_we}, 32'd0);
        check("t2_stall_cycles", stall_cnt, 32'd5);
        check("t2_data", done_dat, 32'hDEADBEEF);

        // 3: sub-word loads, zero-wait ack
        run_access(1'b1, 1'b0, 3'b000, 32'h103, 32'h0, 0, 32'h80018000);
        check("t3_lb", done_dat, 32'hFFFFFF80);
        check("t3_lb_stall", stall_cnt, 32'd2);
        check("t3_lb_addr", cap_addr, 32'h100);
        run_access(1'b1, 1'b0, 3'b100, 32'h103, 32'h0, 0, 32'h80018000);
        check("t3_lbu", done_dat, 32'h00000080);
        run_access(1'b1, 1'b0, 3'b001, 32'h102, 32'h0, 0, 32'h80018000);
        check("t3_lh", done_dat, 32'hFFFF8001);
        run_access(1'b1, 1'b0, 3'b101, 32'h100, 32'h0, 0, 32'h80018000);
        check("t3_lhu", done_dat, 32'h00008000);

        // 4: stores leave the load result untouched
        run_access(1'b0, 1'b1, 3'b000, 32'h201, 32'h12345678, 0, 32'hFFFFFFFF);
        check("t4_sb_be", {28'b0, cap_be}, 32'b0010);
        check("t4_sb_wdata", cap_wdata, 32'h78787878);
        check("t4_sb_we", {31'b0, cap_we}, 32'd1);
        check("t4_sb_addr", cap_addr, 32'h200);
        check("t4_sb_data", done_dat, 32'h00008000);
        run_access(1'b0, 1'b1, 3'b001, 32'h202, 32'h12345678, 0, 32'hFFFFFFFF);
        check("t4_sh_be", {28'b0, cap_be}, 32'b1100);
        check("t4_sh_wdata", cap_wdata, 32'h56785678);
        check("t4_sh_data", done_dat, 32'h00008000);

        // Read and write together: the write wins
        run_access(1'b1, 1'b1, 3'b010, 32'h500, 32'hA5A5A5A5, 0, 32'h11111111);
        check("rw_we", {31'b0, cap_we}, 32'd1);
        check("rw_wdata", cap_wdata, 32'hA5A5A5A5);
        check("rw_data", done_dat, 32'h00008000);

        // 5: misaligned accesses are dropped
        run_access(1'b1, 1'b0, 3'b010, 32'h102, 32'h0, 0, 32'h0);
        check("t5_lw_mis", {31'b0, saw_mis}, 32'd1);
        check("t5_lw_req", req_cnt, 32'd0);
        check("t5_lw_stall", stall_cnt, 32'd0);
        run_access(1'b0, 1'b1, 3'b001, 32'h201, 32'h12345678, 0, 32'h0);
        check("t5_sh_mis", {31'b0, saw_mis}, 32'd1);
        check("t5_sh_req", req_cnt, 32'd0);
        check("t5_sh_stall", stall_cnt, 32'd0);

        // 6: no ack ever, timeout after 4 BUSY cycles
        run_access(1'b1, 1'b0, 3'b010, 32'h400, 32'h0, 1000, 32'h0);
        check("t6_req_cycles", req_cnt, 32'd4);
        check("t6_stall_cycles", stall_cnt, 32'd5);
        check("t6_err_in_done", {31'b0, done_err}, 32'd1);
        check("t6_err_cycles", err_cnt, 32'd1);
        check("t6_data", done_dat, 32'h0);
        @(negedge clk);
        check("t6_err_clear", {31'b0, M_bus_err}, 32'd0);
        check("t6_stall_clear", {31'b0, mem_stall}, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
